// File: rtl/sync_generator_axi_regs.sv
// AXI4-Lite register file for the sync generator: NUM_REGS read/write words,
// flat register view plus a per-register write pulse for the core.
module sync_generator_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          regs_out,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    // Byte-lane merge of new write data into an existing register word.
    function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [NUM_REGS-1:0][DW-1:0] regs_r, regs_nxt_s;
    logic [NUM_REGS-1:0]         pulse_r, pulse_nxt_s;
    logic                        aw_held_r, aw_held_nxt_s;
    logic                        w_held_r, w_held_nxt_s;
    logic [IDX_W-1:0]            aw_idx_r, aw_idx_nxt_s;
    logic [DW-1:0]               w_data_r, w_data_nxt_s;
    logic [SW-1:0]               w_strb_r, w_strb_nxt_s;
    logic                        awready_r, awready_nxt_s;
    logic                        wready_r, wready_nxt_s;
    logic                        bvalid_r, bvalid_nxt_s;
    logic                        arready_r, arready_nxt_s;
    logic                        rvalid_r, rvalid_nxt_s;
    logic [DW-1:0]               rdata_r, rdata_nxt_s;
    logic                        aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic [IDX_W-1:0]            wr_idx_s, rd_idx_s;
    logic [DW-1:0]               wr_data_s, rd_data_s;
    logic [SW-1:0]               wr_strb_s;
    logic                        unused_s;

    // Next-state logic for write holding regs, register file and read path.
    always_comb begin
        aw_hs_s   = S_AXI_AWVALID & awready_r;
        w_hs_s    = S_AXI_WVALID & wready_r;
        ar_hs_s   = S_AXI_ARVALID & arready_r;
        // A beat arriving this edge is used directly so a paired handshake commits at once.
        wr_idx_s  = aw_held_r ? aw_idx_r : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        wr_data_s = w_held_r ? w_data_r : S_AXI_WDATA;
        wr_strb_s = w_held_r ? w_strb_r : S_AXI_WSTRB;
        commit_s  = (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);
        rd_idx_s  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

        aw_held_nxt_s = aw_held_r;
        aw_idx_nxt_s  = aw_idx_r;
        w_held_nxt_s  = w_held_r;
        w_data_nxt_s  = w_data_r;
        w_strb_nxt_s  = w_strb_r;
        if (commit_s) begin
            aw_held_nxt_s = 1'b0;
            w_held_nxt_s  = 1'b0;
        end else begin
            if (aw_hs_s) begin
                aw_held_nxt_s = 1'b1;
                aw_idx_nxt_s  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end else begin
                aw_held_nxt_s = aw_held_r;
            end
            if (w_hs_s) begin
                w_held_nxt_s = 1'b1;
                w_data_nxt_s = S_AXI_WDATA;
                w_strb_nxt_s = S_AXI_WSTRB;
            end else begin
                w_held_nxt_s = w_held_r;
            end
        end

        if (commit_s) begin
            bvalid_nxt_s = 1'b1;
        end else if (bvalid_r & S_AXI_BREADY) begin
            bvalid_nxt_s = 1'b0;
        end else begin
            bvalid_nxt_s = bvalid_r;
        end
        awready_nxt_s = ~aw_held_nxt_s & ~bvalid_nxt_s;
        wready_nxt_s  = ~w_held_nxt_s & ~bvalid_nxt_s;

        rd_data_s = {DW{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_s && (wr_idx_s == IDX_W'(i))) begin
                regs_nxt_s[i]  = byte_merge(regs_r[i], wr_data_s, wr_strb_s);
                pulse_nxt_s[i] = 1'b1;
            end else begin
                regs_nxt_s[i]  = regs_r[i];
                pulse_nxt_s[i] = 1'b0;
            end
            // Reads see the pre-commit contents when sampled on a commit edge.
            if (rd_idx_s == IDX_W'(i)) begin
                rd_data_s = regs_r[i];
            end else begin
                rd_data_s = rd_data_s;
            end
        end

        if (ar_hs_s) begin
            rvalid_nxt_s = 1'b1;
            rdata_nxt_s  = rd_data_s;
        end else if (rvalid_r & S_AXI_RREADY) begin
            rvalid_nxt_s = 1'b0;
            rdata_nxt_s  = rdata_r;
        end else begin
            rvalid_nxt_s = rvalid_r;
            rdata_nxt_s  = rdata_r;
        end
        arready_nxt_s = ~rvalid_nxt_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            regs_r    <= '0;
            pulse_r   <= '0;
            aw_held_r <= 1'b0;
            aw_idx_r  <= '0;
            w_held_r  <= 1'b0;
            w_data_r  <= '0;
            w_strb_r  <= '0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
        end else begin
            regs_r    <= regs_nxt_s;
            pulse_r   <= pulse_nxt_s;
            aw_held_r <= aw_held_nxt_s;
            aw_idx_r  <= aw_idx_nxt_s;
            w_held_r  <= w_held_nxt_s;
            w_data_r  <= w_data_nxt_s;
            w_strb_r  <= w_strb_nxt_s;
            awready_r <= awready_nxt_s;
            wready_r  <= wready_nxt_s;
            bvalid_r  <= bvalid_nxt_s;
            arready_r <= arready_nxt_s;
            rvalid_r  <= rvalid_nxt_s;
            rdata_r   <= rdata_nxt_s;
        end
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = 2'b00;
    assign regs_out      = regs_r;
    assign reg_wr_pulse  = pulse_r;

    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
